// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns MIE/MPIE/MPP and privilege, sequences flush -> update -> redirect.
// Optional U-mode support is enabled by defining USER_MODE_EN.
module trap_ctrl #(
  parameter int FLUSH_TIMEOUT = 15,
  parameter int IRQ_CODE      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_cause,
  input  logic        irq_pending,
  input  logic        mret_req,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  input  logic        flush_ack,
  input  logic        redirect_ready,
  output logic        flush_req,
  output logic        redirect_valid,
  output logic        redirect_is_mret,
  output logic        busy,
  output logic        flush_timeout,
  output logic [1:0]  priv,
  output logic [31:0] mcause,
  output logic [31:0] mstat
);

  typedef enum logic [1:0] {IDLE, FLUSH, UPDATE, REDIRECT} state_t;

  localparam logic [7:0] FLUSH_LIMIT = 8'(FLUSH_TIMEOUT - 1);
  localparam logic [4:0] IRQ_CODE5   = 5'(IRQ_CODE);

  state_t     state;
  logic [7:0] cnt;
  logic       mie;
  logic       mpie;
  logic [1:0] mpp;
  logic [1:0] priv_q;
  logic       ev_mret;
  logic       ev_irq;
  logic [4:0] ev_cause;

  logic       mret_illegal;
  logic       take_exc;
  logic       take_irq;
  logic       take_mret;
  logic       accept;
  logic       unused_wdata;

`ifdef USER_MODE_EN
  assign mret_illegal = mret_req && (priv_q != 2'b11);
  assign unused_wdata = ^{csr_wdata[31:13], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};
`else
  // Without U-mode the core can never leave M, so privilege and MPP are constants.
  assign mpp          = 2'b11;
  assign priv_q       = 2'b11;
  assign mret_illegal = 1'b0;
  assign unused_wdata = ^{csr_wdata[31:8], csr_wdata[6:4], csr_wdata[2:0]};
`endif

  assign take_exc  = exc_req || mret_illegal;
  assign take_irq  = !take_exc && irq_pending && mie;
  assign take_mret = !take_exc && !take_irq && mret_req;
  assign accept    = take_exc || take_irq || take_mret;

  assign priv  = priv_q;
  assign mstat = {19'b0, mpp, 3'b0, mpie, 3'b0, mie, 3'b0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      mie              <= 1'b0;
      mpie             <= 1'b0;
`ifdef USER_MODE_EN
      mpp              <= 2'b11;
      priv_q           <= 2'b11;
`endif
      ev_mret          <= 1'b0;
      ev_irq           <= 1'b0;
      ev_cause         <= 5'd0;
      mcause           <= 32'd0;
      flush_req        <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_is_mret <= 1'b0;
      busy             <= 1'b0;
      flush_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A CSR write in the accepting cycle lands first, so UPDATE sees it.
          if (csr_we) begin
            mie  <= csr_wdata[3];
            mpie <= csr_wdata[7];
`ifdef USER_MODE_EN
            if (csr_wdata[12:11] == 2'b00 || csr_wdata[12:11] == 2'b11)
              mpp <= csr_wdata[12:11];
`endif
          end
          if (accept) begin
            state            <= FLUSH;
            cnt              <= 8'd0;
            flush_req        <= 1'b1;
            busy             <= 1'b1;
            ev_mret          <= take_mret;
            ev_irq           <= take_irq;
            ev_cause         <= exc_req ? exc_cause : 5'd2;
            redirect_is_mret <= take_mret;
          end
        end
        FLUSH: begin
          if (flush_ack || cnt == FLUSH_LIMIT) begin
            state     <= UPDATE;
            flush_req <= 1'b0;
            if (!flush_ack)
              flush_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        UPDATE: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          if (ev_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
`ifdef USER_MODE_EN
            priv_q <= mpp;
            mpp    <= 2'b00;
`endif
          end else begin
            mpie <= mie;
            mie  <= 1'b0;
`ifdef USER_MODE_EN
            mpp    <= priv_q;
            priv_q <= 2'b11;
`endif
            mcause <= ev_irq ? {1'b1, 26'b0, IRQ_CODE5} : {1'b0, 26'b0, ev_cause};
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state            <= IDLE;
            redirect_valid   <= 1'b0;
            redirect_is_mret <= 1'b0;
            busy             <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized self-checking bench for trap_ctrl against a transaction-level status model.
// Builds with or without USER_MODE_EN; the U-mode round trip runs only when it is defined.
module tb_trap_ctrl;

  localparam int TO = 15;
`ifdef USER_MODE_EN
  localparam bit UM = 1'b1;
`else
  localparam bit UM = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic        irq_pending;
  logic        mret_req;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        flush_ack;
  logic        redirect_ready;
  logic        flush_req;
  logic        redirect_valid;
  logic        redirect_is_mret;
  logic        busy;
  logic        flush_timeout;
  logic [1:0]  priv;
  logic [31:0] mcause;
  logic [31:0] mstat;

  int errors = 0;
  int checks = 0;

  // Architectural model of the status state
  bit        m_mie, m_mpie, m_timeout;
  bit [1:0]  m_mpp, m_priv;
  bit [31:0] m_mcause;

  trap_ctrl #(.FLUSH_TIMEOUT(TO), .IRQ_CODE(11)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_cause(exc_cause),
    .irq_pending(irq_pending), .mret_req(mret_req), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .flush_ack(flush_ack), .redirect_ready(redirect_ready),
    .flush_req(flush_req), .redirect_valid(redirect_valid),
    .redirect_is_mret(redirect_is_mret), .busy(busy), .flush_timeout(flush_timeout),
    .priv(priv), .mcause(mcause), .mstat(mstat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_mstat();
    logic [31:0] v = 32'd0;
    v[3]     = m_mie;
    v[7]     = m_mpie;
    v[12:11] = m_mpp;
    return v;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mpp = 2'b11; m_priv = 2'b11;
    m_mcause = 0; m_timeout = 0;
  endtask

  task automatic model_csr_write(input logic [31:0] wd);
    m_mie  = wd[3];
    m_mpie = wd[7];
    if (UM && (wd[12:11] == 2'b00 || wd[12:11] == 2'b11)) m_mpp = wd[12:11];
  endtask

  // Drive one request cycle and follow the resulting sequence to completion.
  task automatic run_event(input bit exc, input logic [4:0] cause, input bit irq,
                           input bit mret, input bit we, input logic [31:0] wd,
                           input int ack_delay, input int ready_delay, input bit busy_we);
    int kind;
    logic [4:0] ecause;
    int fcount;
    int exp_f;
    kind = 0; ecause = cause;
    if (exc) kind = 1;
    else if (mret && m_priv != 2'b11) begin kind = 1; ecause = 5'd2; end
    else if (irq && m_mie) kind = 2;
    else if (mret) kind = 3;
    exc_req = exc; exc_cause = cause; irq_pending = irq; mret_req = mret;
    csr_we = we; csr_wdata = wd; flush_ack = 0; redirect_ready = 0;
    if (we) model_csr_write(wd);
    @(negedge clk);
    exc_req = 0; irq_pending = 0; mret_req = 0; csr_we = 0;
    if (kind == 0) begin
      checks++;
      if (busy !== 1'b0 || mstat !== model_mstat()) begin
        errors++;
        $display("[TB] FAIL idle_write: busy=%b mstat=%h required busy=0 mstat=%h", busy, mstat, model_mstat());
      end
      return;
    end
    fcount = 0;
    for (int c = 0; c < 40 && flush_req === 1'b1; c++) begin
      flush_ack = (fcount >= ack_delay);
      fcount++;
      @(negedge clk);
    end
    flush_ack = 0;
    exp_f = (ack_delay + 1 < TO) ? ack_delay + 1 : TO;
    checks++;
    if (fcount != exp_f) begin
      errors++;
      $display("[TB] FAIL flush_len: got %0d cycles required %0d", fcount, exp_f);
    end
    checks++;
    if (busy !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL update_cycle: busy=%b rv=%b required busy=1 rv=0", busy, redirect_valid);
    end
    if (ack_delay >= TO) m_timeout = 1;
    if (kind == 3) begin
      m_mie = m_mpie; m_mpie = 1;
      if (UM) begin m_priv = m_mpp; m_mpp = 2'b00; end
    end else begin
      m_mpie = m_mie; m_mie = 0;
      m_mpp = UM ? m_priv : 2'b11;
      m_priv = 2'b11;
      m_mcause = (kind == 2) ? 32'h8000_0000 + 32'd11 : {27'd0, ecause};
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_is_mret !== (kind == 3)) begin
      errors++;
      $display("[TB] FAIL redirect: rv=%b is_mret=%b required rv=1 is_mret=%b", redirect_valid, redirect_is_mret, kind == 3);
    end
    checks++;
    if (mstat !== model_mstat() || priv !== m_priv || mcause !== m_mcause || flush_timeout !== m_timeout) begin
      errors++;
      $display("[TB] FAIL status: mstat=%h priv=%b mcause=%h to=%b required %h %b %h %b",
               mstat, priv, mcause, flush_timeout, model_mstat(), m_priv, m_mcause, m_timeout);
    end
    for (int r = 0; r < ready_delay; r++) begin
      csr_we = busy_we; csr_wdata = $urandom;
      @(negedge clk);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_is_mret !== (kind == 3)) begin
        errors++;
        $display("[TB] FAIL redirect_hold: rv=%b is_mret=%b required 1 %b", redirect_valid, redirect_is_mret, kind == 3);
      end
    end
    csr_we = busy_we; csr_wdata = $urandom; redirect_ready = 1;
    @(negedge clk);
    redirect_ready = 0; csr_we = 0;
    checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0 || mstat !== model_mstat()) begin
      errors++;
      $display("[TB] FAIL return_idle: rv=%b busy=%b mstat=%h required 0 0 %h", redirect_valid, busy, mstat, model_mstat());
    end
  endtask

  task automatic test_reset();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    model_reset();
    checks++;
    if (mstat !== 32'h0000_1800 || priv !== 2'b11 || busy !== 1'b0 || mcause !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset: mstat=%h priv=%b busy=%b mcause=%h required 00001800 11 0 0", mstat, priv, busy, mcause);
    end
    checks++;
    if (flush_req !== 1'b0 || redirect_valid !== 1'b0 || flush_timeout !== 1'b0 || redirect_is_mret !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outs: fr=%b rv=%b to=%b im=%b required all 0", flush_req, redirect_valid, flush_timeout, redirect_is_mret);
    end
  endtask

  task automatic test_csr_irq();
    run_event(0, 0, 0, 0, 1, 32'h0000_0008, 0, 0, 0);
    run_event(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mstat !== 32'h0000_1880 || mcause !== 32'h8000_000B) begin
      errors++;
      $display("[TB] FAIL csr_irq: mstat=%h mcause=%h required 00001880 8000000b", mstat, mcause);
    end
  endtask

  task automatic test_user_round_trip();
    run_event(0, 0, 0, 0, 1, 32'h0000_0088, 0, 0, 0);
    run_event(0, 0, 0, 1, 0, 0, 1, 1, 0);
    checks++;
    if (mstat !== 32'h0000_0088 || priv !== 2'b00) begin
      errors++;
      $display("[TB] FAIL to_umode: mstat=%h priv=%b required 00000088 00", mstat, priv);
    end
    run_event(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (mcause !== 32'd2 || priv !== 2'b11 || mstat[12:11] !== 2'b00) begin
      errors++;
      $display("[TB] FAIL umode_mret: mcause=%h priv=%b mpp=%b required 2 11 00", mcause, priv, mstat[12:11]);
    end
  endtask

  task automatic test_flush_timeout();
    run_event(1, 5'd5, 0, 0, 0, 0, 1000, 0, 0);
    checks++;
    if (flush_timeout !== 1'b1 || mcause !== 32'd5) begin
      errors++;
      $display("[TB] FAIL timeout: to=%b mcause=%h required 1 5", flush_timeout, mcause);
    end
  endtask

  task automatic test_collision();
    run_event(0, 0, 0, 0, 1, 32'h0000_0008, 0, 0, 0);
    run_event(1, 5'd3, 1, 0, 0, 0, 2, 1, 0);
    checks++;
    if (mcause !== 32'd3) begin
      errors++;
      $display("[TB] FAIL collision: mcause=%h required 3", mcause);
    end
  endtask

  task automatic test_busy_csr();
    run_event(1, 5'd4, 0, 0, 0, 0, 0, 3, 1);
  endtask

  task automatic test_reset_mid();
    exc_req = 1; exc_cause = 5'd7;
    @(negedge clk);
    exc_req = 0;
    @(negedge clk);
    checks++;
    if (flush_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_flush: flush_req=%b required 1", flush_req);
    end
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    checks++;
    if (flush_req !== 1'b0 || busy !== 1'b0 || mstat !== 32'h0000_1800 || mcause !== 32'd0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: fr=%b busy=%b mstat=%h mcause=%h rv=%b required 0 0 00001800 0 0",
               flush_req, busy, mstat, mcause, redirect_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_event(($urandom % 4) == 0, 5'($urandom % 32), ($urandom % 3) == 0,
                ($urandom % 4) == 0, ($urandom % 3) == 0, $urandom,
                int'($urandom % 18), int'($urandom % 4), bit'($urandom % 2));
    end
  endtask

  initial begin
    rst = 0; exc_req = 0; exc_cause = 0; irq_pending = 0; mret_req = 0;
    csr_we = 0; csr_wdata = 0; flush_ack = 0; redirect_ready = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_csr_irq();
    if (UM) test_user_round_trip();
    test_flush_timeout();
    test_collision();
    test_busy_csr();
    test_random();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
